memory_decompress_reader: RTL and testbench

//  Burst read engine for the compressed word store: accepts a (start address, length) command,

---
 rtl/memdec_pkg.sv | 25 ++
 rtl/memdec_skid_fifo.sv | 78 +++++++
 rtl/memory_decompress_reader.sv | 180 ++++++++++++++++++
 tb/tb_memory_decompress_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memdec_pkg.sv
// ----------------------------------------------------------------------------
// memdec_pkg
//   Shared types and constants for the compressed-store burst reader.
//   - memdec_state_e : burst engine states (IDLE, FETCH, DRAIN)
//   - FIFO_DEPTH     : return-buffer depth; the read-credit rule depends on it
//   - FIFO_CNT_W     : width of the return-buffer occupancy count
//   - fill_width()   : number of fill bits appended when expanding an entry
// ----------------------------------------------------------------------------
package memdec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } memdec_state_e;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = 2;

  // Width of the low-order fill appended below a stored entry.
  function automatic int unsigned fill_width(input int unsigned bw, input int unsigned cbw);
    return bw - cbw;
  endfunction

endpackage

// File: rtl/memdec_skid_fifo.sv
// ----------------------------------------------------------------------------
// memdec_skid_fifo
//   Two-entry FIFO buffering decompressed words (data + last tag) between the
//   memory return path and the output handshake. Push and pop may coincide,
//   including when full. Contents are flushed by the synchronous reset.
// Ports
//   clk, rst     : clock, synchronous active-high reset (flush)
//   push_i       : write push_data_i this cycle
//   push_data_i  : W-bit entry to store
//   pop_i        : remove the head entry this cycle
//   head_o       : oldest entry (meaningful only when !empty_o)
//   count_o      : occupancy 0..2
//   empty_o      : no entries stored
//   full_o       : both entries occupied
// ----------------------------------------------------------------------------
module memdec_skid_fifo
  import memdec_pkg::*;
#(
  parameter int unsigned W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [W-1:0]          push_data_i,
  input  logic                  pop_i,
  output logic [W-1:0]          head_o,
  output logic [FIFO_CNT_W-1:0] count_o,
  output logic                  empty_o,
  output logic                  full_o
);

  logic [W-1:0]          mem_q [FIFO_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic [FIFO_CNT_W-1:0] count_d;
  logic                  do_push;
  logic                  do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Qualify push/pop against occupancy and compute the next occupancy.
  always_comb begin
    do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    do_push = push_i && (!full_o || do_pop);
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy; reset flushes everything to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= {W{1'b0}};
      mem_q[1] <= {W{1'b0}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_decompress_reader.sv
// ----------------------------------------------------------------------------
// memory_decompress_reader
//   Burst read engine for the compressed word store. Accepts (addr, len),
//   reads COMPRESS_BW-bit entries through a 1-cycle-latency read port, expands
//   each to BW bits as {entry, FILL} and streams them out on valid/ready with
//   an end-of-burst marker. A done pulse follows the last handshake.
// Configuration
//   MEMDEC_ROUND_FILL_EN : when defined, FILL is a 1 followed by zeros
//                          (midpoint reconstruction, 0xAB -> 0xAB80);
//                          otherwise FILL is all zeros (0xAB -> 0xAB00).
// Ports
//   clk, rst        : clock, synchronous active-high reset (aborts a burst)
//   cmd_valid_i     : command offered
//   cmd_ready_o     : engine idle; command taken on cmd_valid_i && cmd_ready_o
//   cmd_addr_i      : first entry address
//   cmd_len_i       : entry count, 0 = no-op, legal 0..2**AW
//   mem_rd_en_o     : read strobe to compressed store
//   mem_rd_addr_o   : read address (wraps modulo 2**AW)
//   mem_rd_data_i   : read data, valid the cycle after mem_rd_en_o
//   out_valid_o     : decompressed word available
//   out_ready_i     : consumer accepts word
//   out_data_o      : decompressed word
//   out_last_o      : out_data_o is the final word of the burst
//   busy_o          : burst in progress
//   done_o          : one-cycle completion pulse
// Note: COMPRESS_BW must be strictly less than BW.
// ----------------------------------------------------------------------------
module memory_decompress_reader
  import memdec_pkg::*;
#(
  parameter int unsigned BW          = 16,
  parameter int unsigned COMPRESS_BW = 8,
  parameter int unsigned AW          = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [AW-1:0]          cmd_addr_i,
  input  logic [AW:0]            cmd_len_i,
  output logic                   mem_rd_en_o,
  output logic [AW-1:0]          mem_rd_addr_o,
  input  logic [COMPRESS_BW-1:0] mem_rd_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [BW-1:0]          out_data_o,
  output logic                   out_last_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned FW = fill_width(BW, COMPRESS_BW);

`ifdef MEMDEC_ROUND_FILL_EN
  // Only the MSB of the fill set: reconstruct at the quantisation midpoint.
  localparam logic [FW-1:0] FILL = ~({FW{1'b1}} >> 1);
`else
  localparam logic [FW-1:0] FILL = {FW{1'b0}};
`endif

  localparam logic [AW-1:0] ADDR_ONE = ~({AW{1'b1}} << 1);
  localparam logic [AW:0]   CNT_ONE  = ~({(AW+1){1'b1}} << 1);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};

  memdec_state_e state_q;
  logic [AW:0]   issue_rem_q;  // reads still to be issued
  logic [AW:0]   ret_rem_q;    // words still to be returned from memory
  logic [AW-1:0] rd_addr_q;
  logic          in_flight_q;  // a read was issued last cycle; data arrives now
  logic          done_q;

  logic [BW:0]           fifo_head;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;

  logic                  cmd_fire;
  logic                  pop;
  logic                  push;
  logic                  push_last;
  logic [BW:0]           push_word;
  logic [FIFO_CNT_W-1:0] eff_count;
  logic                  credit_ok;
  logic                  rd_fire;
  logic                  last_fire;

  // Handshakes, read credit and the word pushed from the memory return path.
  always_comb begin
    cmd_fire  = cmd_valid_i && cmd_ready_o;
    pop       = !rst && !fifo_empty && out_ready_i;
    // Occupancy after this cycle's pop; lets a pop free a slot for a new read
    // in the same cycle so a full-rate stream keeps one read per cycle.
    eff_count = fifo_count - {1'b0, pop};
    if (fifo_full && !pop) begin
      credit_ok = 1'b0;
    end else begin
      credit_ok = (({1'b0, eff_count} + {2'b00, in_flight_q}) < 3'd2);
    end
    rd_fire   = !rst && (state_q == FETCH) && (issue_rem_q != CNT_ZERO) && credit_ok;
    push      = !rst && in_flight_q;
    push_last = (ret_rem_q == CNT_ONE);
    push_word = {push_last, mem_rd_data_i, FILL};
    last_fire = pop && fifo_head[BW];
  end

  memdec_skid_fifo #(
    .W (BW + 1)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_word),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign cmd_ready_o   = (state_q == IDLE) && !rst;
  assign mem_rd_en_o   = rd_fire;
  assign mem_rd_addr_o = rd_addr_q;
  assign out_valid_o   = !fifo_empty;
  // Mask the head while empty so idle outputs read as zero, not stale data.
  assign out_data_o    = fifo_empty ? {BW{1'b0}} : fifo_head[BW-1:0];
  assign out_last_o    = !fifo_empty && fifo_head[BW];
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;

  // Burst FSM, issue/return counters, read address and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_rem_q <= CNT_ZERO;
      ret_rem_q   <= CNT_ZERO;
      rd_addr_q   <= {AW{1'b0}};
      in_flight_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      in_flight_q <= rd_fire;
      if (rd_fire) begin
        rd_addr_q   <= rd_addr_q + ADDR_ONE;
        issue_rem_q <= issue_rem_q - CNT_ONE;
      end
      if (push) begin
        ret_rem_q <= ret_rem_q - CNT_ONE;
      end
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_len_i == CNT_ZERO) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= FETCH;
              issue_rem_q <= cmd_len_i;
              ret_rem_q   <= cmd_len_i;
              rd_addr_q   <= cmd_addr_i;
            end
          end
        end
        FETCH: begin
          if (rd_fire && (issue_rem_q == CNT_ONE)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_fire) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_decompress_reader.sv
// ----------------------------------------------------------------------------
// tb_memory_decompress_reader
//   Directed bench for memory_decompress_reader with a behavioural compressed
//   store. Expected read addresses and output words are queued when a command
//   is accepted and compared as the DUT issues reads and hands words out.
// ----------------------------------------------------------------------------
module tb_memory_decompress_reader;

`ifdef MEMDEC_ROUND_FILL_EN
  localparam logic [7:0] FILL_TB = 8'h80;
`else
  localparam logic [7:0] FILL_TB = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_addr;
  logic [4:0]  cmd_len;
  logic        mem_rd_en;
  logic [3:0]  mem_rd_addr;
  logic [7:0]  mem_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [7:0]  mem [16];

  always #5 clk = ~clk;

  memory_decompress_reader dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_addr_i    (cmd_addr),
    .cmd_len_i     (cmd_len),
    .mem_rd_en_o   (mem_rd_en),
    .mem_rd_addr_o (mem_rd_addr),
    .mem_rd_data_i (mem_rd_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .out_last_o    (out_last),
    .busy_o        (busy),
    .done_o        (done)
  );

  // One-cycle-latency compressed store.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [3:0]  exp_addr_q[$];
  logic [16:0] exp_word_q[$];

  int   issued, delivered;
  int   accept_cyc, prev_hs_cyc, last_hs_cyc, done_cyc;
  bit   first_hs, lat_chk, consec_chk, bp_chk;
  bit   seen_done, held_valid;
  logic rdy_at_done, busy_at_done;
  logic [16:0] held_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_true(input string tag, input logic cond);
    checks++;
    assert (cond === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0b expected 1", tag, cond);
    end
  endtask

  // Sample DUT outputs mid-cycle and compare against the scoreboard.
  task automatic monitor();
    logic [16:0] e;
    if (done) begin
      seen_done    = 1'b1;
      done_cyc     = cyc;
      rdy_at_done  = cmd_ready;
      busy_at_done = busy;
    end
    if (mem_rd_en) begin
      check_true("rd_expected", exp_addr_q.size() != 0);
      if (exp_addr_q.size() != 0) check("rd_addr", mem_rd_addr, exp_addr_q.pop_front());
      issued++;
    end
    if (out_valid) begin
      check_true("valid_expected", exp_word_q.size() != 0);
      if (held_valid) check("stall_stable", {out_last, out_data}, held_word);
      if (out_ready) begin
        if (exp_word_q.size() != 0) begin
          e = exp_word_q.pop_front();
          check("out_data", out_data, e[15:0]);
          check("out_last", out_last, e[16]);
        end
        if (first_hs && lat_chk) check("first_latency", cyc, accept_cyc + 2);
        if (!first_hs && consec_chk) check("consecutive", cyc, prev_hs_cyc + 1);
        first_hs    = 1'b0;
        prev_hs_cyc = cyc;
        if (out_last) last_hs_cyc = cyc;
        delivered++;
        held_valid = 1'b0;
      end else begin
        held_valid = 1'b1;
        held_word  = {out_last, out_data};
      end
    end else begin
      held_valid = 1'b0;
    end
    if (bp_chk) check_true("outstanding_le2", (issued - delivered) <= 2);
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] a, input logic [4:0] l);
    int budget;
    logic [3:0] ad;
    budget = 50;
    while (!cmd_ready && budget > 0) begin
      step();
      budget--;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    ad = a;
    for (int i = 0; i < int'(l); i++) begin
      exp_addr_q.push_back(ad);
      exp_word_q.push_back({(i == int'(l) - 1), mem[ad], FILL_TB});
      ad = ad + 4'd1;
    end
    seen_done = 1'b0;
    first_hs  = 1'b1;
    step();
    accept_cyc = cyc;
    cmd_valid  = 1'b0;
  endtask

  // Wait (bounded) for done; zero_len selects the expected pulse timing.
  task automatic wait_done(input string tag, input bit zero_len);
    int budget;
    budget = 100;
    while (!seen_done && budget > 0) begin
      step();
      budget--;
    end
    check({tag, "_done_seen"}, seen_done, 1'b1);
    if (seen_done) begin
      check({tag, "_done_cyc"}, done_cyc, zero_len ? accept_cyc : last_hs_cyc + 1);
      check({tag, "_ready_at_done"}, rdy_at_done, 1'b1);
      check({tag, "_busy_at_done"}, busy_at_done, 1'b0);
    end
    check({tag, "_sb_words_left"}, exp_word_q.size(), 0);
    check({tag, "_sb_reads_left"}, exp_addr_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    #1;
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    check({tag, "_rd_en"}, mem_rd_en, 1'b0);
    check({tag, "_rd_addr"}, mem_rd_addr, 4'd0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"}, out_data, 16'h0000);
    check({tag, "_out_last"}, out_last, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 4'd0; cmd_len = 5'd0; out_ready = 1'b0;
    issued = 0; delivered = 0; first_hs = 1'b1; held_valid = 1'b0; seen_done = 1'b0;
    lat_chk = 1'b0; consec_chk = 1'b0; bp_chk = 1'b0;
    accept_cyc = 0; prev_hs_cyc = 0; last_hs_cyc = 0; done_cyc = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h40 + i);
    mem[3] = 8'h12; mem[4] = 8'h34; mem[5] = 8'h56; mem[6] = 8'h78;
    mem[7] = 8'hAB;
    mem[14] = 8'h9A; mem[15] = 8'hBC; mem[0] = 8'hDE; mem[1] = 8'hF0;
    repeat (3) step();
    rst = 1'b0;
    check_reset_vals("reset");

    // 1: basic burst at full rate
    out_ready = 1'b1; lat_chk = 1'b1; consec_chk = 1'b1;
    send_cmd(4'd3, 5'd4);
    wait_done("basic", 1'b0);

    // 2: address wrap 14,15,0,1
    send_cmd(4'd14, 5'd4);
    wait_done("wrap", 1'b0);

    // 3: backpressure mid-burst
    lat_chk = 1'b0; consec_chk = 1'b0; bp_chk = 1'b1;
    issued = 0; delivered = 0;
    send_cmd(4'd8, 5'd6);
    for (int b = 0; b < 20 && delivered < 2; b++) step();
    check("bp_two_delivered", delivered, 2);
    out_ready = 1'b0;
    repeat (5) step();
    out_ready = 1'b1;
    wait_done("bp", 1'b0);
    bp_chk = 1'b0;

    // 4: zero-length command
    send_cmd(4'd5, 5'd0);
    wait_done("len0", 1'b1);
    repeat (3) step();

    // 6: fill pattern for a single entry
    lat_chk = 1'b1;
    send_cmd(4'd7, 5'd1);
    wait_done("fill", 1'b0);

    // 5: reset after 2 of 8 words, then a clean burst
    lat_chk = 1'b0;
    delivered = 0;
    send_cmd(4'd0, 5'd8);
    for (int b = 0; b < 20 && delivered < 2; b++) step();
    check("rst_two_delivered", delivered, 2);
    rst = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b0;
    exp_addr_q.delete(); exp_word_q.delete(); held_valid = 1'b0;
    check_reset_vals("midrst");
    out_ready = 1'b1;
    repeat (3) step();
    check("midrst_no_done", seen_done, 1'b0);
    mem[0] = 8'h11; mem[1] = 8'h22;
    lat_chk = 1'b1; consec_chk = 1'b1;
    send_cmd(4'd0, 5'd2);
    wait_done("after_rst", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
